// File: rtl/reg_file_onehot_if.sv
// Bus bundle for the one-hot register file: the write-back write port, two read
// indices and the read data / error flag returned by the register file.
interface reg_file_onehot_if #(
  parameter int unsigned WIDTH = 32
);
  logic             regWrite;
  logic [7:0]       decOut;
  logic [WIDTH-1:0] writeData;
  logic [2:0]       srcReg1;
  logic [2:0]       srcReg2;
  logic [WIDTH-1:0] regData1;
  logic [WIDTH-1:0] regData2;
  logic             wrErr;

  // Write-back stage / reader side
  modport master (
    output regWrite, decOut, writeData, srcReg1, srcReg2,
    input  regData1, regData2, wrErr
  );

  // Register file side
  modport slave (
    input  regWrite, decOut, writeData, srcReg1, srcReg2,
    output regData1, regData2, wrErr
  );
endinterface

// File: rtl/reg_file_onehot.sv
// Eight-entry register file written through a one-hot select vector.
// Two combinational read ports with same-cycle write-through bypass, and a
// sticky flag for write attempts whose select is not exactly one-hot.
module reg_file_onehot #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  reg_file_onehot_if.slave bus
);
  localparam int NumRegs = 8;

  logic [WIDTH-1:0] regs_q [NumRegs];
  logic [WIDTH-1:0] regs_d [NumRegs];
  logic             wr_err_q;
  logic             wr_err_d;
  logic             sel_valid;
  logic             wr_fire;
  logic             wr_bad;
  logic             byp1;
  logic             byp2;

  // Classify the select: nonzero and clearing its lowest set bit leaves zero.
  always_comb begin
    sel_valid = (bus.decOut != 8'd0) && ((bus.decOut & (bus.decOut - 8'd1)) == 8'd0);
    wr_fire   = bus.regWrite && sel_valid;
    wr_bad    = bus.regWrite && !sel_valid;
  end

  // Next-state: only the selected register loads on a valid write; error is sticky.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = (wr_fire && bus.decOut[i]) ? bus.writeData : regs_q[i];
    end
    wr_err_d = wr_err_q | wr_bad;
  end

  // State registers; asynchronous reset clears storage and the error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_err_q <= wr_err_d;
    end
  end

  // Read ports: the value being written this cycle wins over the stored one.
  always_comb begin
    byp1         = wr_fire && bus.decOut[bus.srcReg1];
    byp2         = wr_fire && bus.decOut[bus.srcReg2];
    bus.regData1 = byp1 ? bus.writeData : regs_q[bus.srcReg1];
    bus.regData2 = byp2 ? bus.writeData : regs_q[bus.srcReg2];
    bus.wrErr    = wr_err_q;
  end
endmodule
